wbu_stream_arbiter: RTL and testbench
=====================================

// Module: wbu_stream_arbiter
//
// PURPOSE
//  Shares the single debug-bus codeword decompressor between two upstream
//  36-bit codeword sources (A, B), e.g. UART and a second host link.
//  Grants one source at a time for a whole burst, because the decompressor's
//  codeword table is shared stream state.
//  Paces accepted words at least MIN_GAP clocks apart. This is the spacing the
//  4-stage decompressor pipeline needs while its input register stays stable.
//  Sits between the line decoders and the decompressor's i_stb/i_word inputs.
//
// PARAMETERS
//  MIN_GAP       3   min clocks between successive o_stb pulses (>=1)
//  IDLE_TIMEOUT  16  owner-idle clocks before the grant is released (>=2)
//  LGTIMEOUT     5   width of idle counter; must hold IDLE_TIMEOUT
//
// PORTS
//  i_clk        in   1   system clock
//  i_reset_n    in   1   asynchronous, active-low reset
//  i_a_stb      in   1   source A word valid
//  i_a_word     in   36  source A codeword
//  i_a_last     in   1   with i_a_stb: final word of A's burst
//  o_a_busy     out  1   A word not accepted this clock; hold it
//  o_a_fresh    out  1   1-clk pulse: A newly granted, A must restart its
//                        compression table
//  i_b_stb, i_b_word, i_b_last, o_b_busy, o_b_fresh   same, for source B
//  o_stb        out  1   word strobe to decompressor i_stb
//  o_word       out  36  codeword to decompressor i_word
//  o_src        out  1   source of the current o_word (0=A, 1=B)
//
// BEHAVIOUR
//  - Reset (async, i_reset_n=0):
//      state=IDLE, o_stb=0, o_word=0, o_src=0.
//      o_a_busy=o_b_busy=1, o_x_fresh=0, gap=0, idle=0, last_served=B.
//  - States:
//      IDLE:   both busy. Next clock: if exactly one i_x_stb, go to OWN_x.
//              If both, go to OWN_x where x != last_served (round robin).
//              Entering OWN_x pulses o_x_fresh for that one clock and sets
//              last_served=x.
//      OWN_x:  o_x_busy = !(gap==0), combinational. Other source is busy.
//  - Accept (i_x_stb && !o_x_busy):
//      next clock o_stb=1, o_word=i_x_word, o_src=x.
//      gap<=MIN_GAP-1; idle<=0.
//      Latency is 1 clock. Accepts are spaced exactly MIN_GAP clocks under
//      continuous request (cycles 0,3,6 for MIN_GAP=3).
//      o_stb is high for one clock only. o_word holds its value until the
//      next accept.
//  - gap decrements to 0 and saturates.
//    idle increments while in OWN_x with no accept and saturates at
//    IDLE_TIMEOUT.
//  - Release: go to IDLE once gap==0 and either
//      (a) the last accepted word carried i_x_last, or
//      (b) idle==IDLE_TIMEOUT.
//    No accept occurs on the release clock.
//  - A request from the non-owner never pre-empts the owner. It waits for
//    release.
//  - Word on the grant clock: A source asserting i_x_stb while in IDLE is not
//    accepted on that clock. It is accepted first in OWN_x, when gap==0.
//  - Reset mid-burst: the word in flight is dropped. The next grant re-issues
//    o_x_fresh.
//
// CONFIGURATION
//  WBUARB_PRIORITY_EN
//    defined:   on a tie in IDLE, A always wins (fixed priority);
//               last_served is ignored.
//    undefined: round robin, as above.
//  Pacing and release rules are identical in both builds.
//
// TESTING
//  1. Reset, A streams 4 words, i_a_last on 4th, MIN_GAP=3:
//     o_a_fresh pulses once; o_stb at +1, +4, +7, +10 after first accept;
//     o_src=0; then IDLE.
//  2. A and B both request from IDLE after reset:
//     A granted (last_served=B). After A's last word, B granted with
//     o_b_fresh. In the WBUARB_PRIORITY_EN build, a repeated tie grants A
//     again.
//  3. A owns, then stops. B requests throughout:
//     B stays busy for exactly IDLE_TIMEOUT(16) idle clocks plus 1 release
//     clock, then is granted.
//  4. Owner holds i_a_stb high constantly with MIN_GAP=1:
//     one o_stb per clock; o_word tracks input 1 clock later.
//  5. Assert i_reset_n=0 mid-gap, 1 clock after an accept:
//     o_stb=0 and both busy immediately; after release, a new grant pulses
//     o_x_fresh.
//  6. Non-owner toggles i_b_stb every clock during A's burst:
//     no B word reaches o_word; o_b_busy=1 throughout.

Source files
------------

// File: rtl/wbu_stream_arbiter.sv
// Two-source burst arbiter in front of the shared codeword decompressor.
// Optional macro WBUARB_PRIORITY_EN: source A wins every idle tie (default is round robin).
module wbu_stream_arbiter #(
  parameter int MIN_GAP      = 3,
  parameter int IDLE_TIMEOUT = 16,
  parameter int LGTIMEOUT    = 5
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_a_stb,
  input  logic [35:0] i_a_word,
  input  logic        i_a_last,
  output logic        o_a_busy,
  output logic        o_a_fresh,
  input  logic        i_b_stb,
  input  logic [35:0] i_b_word,
  input  logic        i_b_last,
  output logic        o_b_busy,
  output logic        o_b_fresh,
  output logic        o_stb,
  output logic [35:0] o_word,
  output logic        o_src
);

  localparam int LGGAP = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [LGGAP-1:0]     GAP_RELOAD = LGGAP'(MIN_GAP - 1);
  localparam logic [LGTIMEOUT-1:0] IDLE_MAX   = LGTIMEOUT'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t               r_state;
  logic [LGGAP-1:0]     r_gap;
  logic [LGTIMEOUT-1:0] r_idle;
  logic                 r_last_flag;
`ifndef WBUARB_PRIORITY_EN
  logic                 r_last_served;
`endif

  logic w_gap_zero;
  logic w_release;
  logic w_a_ready;
  logic w_b_ready;
  logic w_a_accept;
  logic w_b_accept;
  logic w_pick_b;

  // The release clock never accepts, so the owner stays busy while handing back.
  assign w_gap_zero = (r_gap == '0);
  assign w_release  = (r_state != S_IDLE) && w_gap_zero &&
                      (r_last_flag || (r_idle == IDLE_MAX));
  assign w_a_ready  = (r_state == S_OWN_A) && w_gap_zero && !w_release;
  assign w_b_ready  = (r_state == S_OWN_B) && w_gap_zero && !w_release;
  assign o_a_busy   = !w_a_ready;
  assign o_b_busy   = !w_b_ready;
  assign w_a_accept = i_a_stb && w_a_ready;
  assign w_b_accept = i_b_stb && w_b_ready;

`ifdef WBUARB_PRIORITY_EN
  assign w_pick_b = i_b_stb && !i_a_stb;
`else
  assign w_pick_b = i_b_stb && (!i_a_stb || !r_last_served);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_idle      <= '0;
      r_last_flag <= 1'b0;
`ifndef WBUARB_PRIORITY_EN
      r_last_served <= 1'b1;
`endif
      o_stb       <= 1'b0;
      o_word      <= '0;
      o_src       <= 1'b0;
      o_a_fresh   <= 1'b0;
      o_b_fresh   <= 1'b0;
    end else begin
      o_stb     <= 1'b0;
      o_a_fresh <= 1'b0;
      o_b_fresh <= 1'b0;
      if (!w_gap_zero)
        r_gap <= r_gap - LGGAP'(1);

      case (r_state)
        S_IDLE: begin
          r_idle      <= '0;
          r_last_flag <= 1'b0;
          if (w_pick_b) begin
            r_state   <= S_OWN_B;
            o_b_fresh <= 1'b1;
`ifndef WBUARB_PRIORITY_EN
            r_last_served <= 1'b1;
`endif
          end else if (i_a_stb) begin
            r_state   <= S_OWN_A;
            o_a_fresh <= 1'b1;
`ifndef WBUARB_PRIORITY_EN
            r_last_served <= 1'b0;
`endif
          end
        end
        default: begin
          if (w_release) begin
            r_state <= S_IDLE;
          end else if (w_a_accept || w_b_accept) begin
            o_stb       <= 1'b1;
            o_word      <= w_a_accept ? i_a_word : i_b_word;
            o_src       <= w_b_accept;
            r_last_flag <= w_a_accept ? i_a_last : i_b_last;
            r_gap       <= GAP_RELOAD;
            r_idle      <= '0;
          end else if (r_idle != IDLE_MAX) begin
            r_idle <= r_idle + LGTIMEOUT'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbu_stream_arbiter.sv
// Scoreboard bench for wbu_stream_arbiter: default-gap instance plus a MIN_GAP=1 instance.
module tb_wbu_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_stb = 1'b0, a_last = 1'b0, b_stb = 1'b0, b_last = 1'b0;
  logic [35:0] a_word = '0, b_word = '0;
  logic        a_busy, a_fresh, b_busy, b_fresh, o_stb, o_src;
  logic [35:0] o_word;

  logic        a1_stb = 1'b0, a1_last = 1'b0;
  logic [35:0] a1_word = '0;
  logic        a1_busy, a1_fresh, b1_busy, b1_fresh, o1_stb, o1_src;
  logic [35:0] o1_word;

  int total = 0;
  int bad = 0;
  int tickNo = 0;
  logic [36:0] qa[$];
  logic [36:0] qb[$];
  logic [36:0] sbq[$];
  logic [35:0] sb1[$];
  logic bToggle = 1'b0;
  logic preBBusy, accA, accB;

  wbu_stream_arbiter u_dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_stb(a_stb), .i_a_word(a_word), .i_a_last(a_last),
    .o_a_busy(a_busy), .o_a_fresh(a_fresh),
    .i_b_stb(b_stb), .i_b_word(b_word), .i_b_last(b_last),
    .o_b_busy(b_busy), .o_b_fresh(b_fresh),
    .o_stb(o_stb), .o_word(o_word), .o_src(o_src)
  );

  wbu_stream_arbiter #(.MIN_GAP(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_stb(a1_stb), .i_a_word(a1_word), .i_a_last(a1_last),
    .o_a_busy(a1_busy), .o_a_fresh(a1_fresh),
    .i_b_stb(1'b0), .i_b_word(36'h0), .i_b_last(1'b0),
    .o_b_busy(b1_busy), .o_b_fresh(b1_fresh),
    .o_stb(o1_stb), .o_word(o1_word), .o_src(o1_src)
  );

  always #5 clk = ~clk;

  // Present the head of each source queue as that source's current word
  task automatic drive();
    a_stb  = (qa.size() > 0);
    a_word = a_stb ? qa[0][35:0] : 36'h0;
    a_last = a_stb ? qa[0][36] : 1'b0;
    if (!bToggle) begin
      b_stb  = (qb.size() > 0);
      b_word = b_stb ? qb[0][35:0] : 36'h0;
      b_last = b_stb ? qb[0][36] : 1'b0;
    end
  endtask

  // One clock: sample the handshake mid-cycle, then land 1ns after the edge
  task automatic tick();
    drive();
    if (bToggle) begin
      b_stb  = ~b_stb;
      b_word = 36'hBAD00BAD0;
      b_last = 1'b0;
    end
    @(negedge clk);
    preBBusy = b_busy;
    accA = a_stb && !a_busy;
    accB = b_stb && !b_busy;
    if (accA) void'(qa.pop_front());
    if (accB && !bToggle) void'(qb.pop_front());
    @(posedge clk);
    #1;
    tickNo++;
    drive();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (o_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb: got %b required 0", o_stb); end
    total++; if (o_word !== 36'h0) begin bad++; $display("[TB] FAIL reset_word: got %h required 0", o_word); end
    total++; if (o_src !== 1'b0) begin bad++; $display("[TB] FAIL reset_src: got %b required 0", o_src); end
    total++; if ({a_busy, b_busy} !== 2'b11) begin bad++; $display("[TB] FAIL reset_busy: got %b required 11", {a_busy, b_busy}); end
    total++; if ({a_fresh, b_fresh} !== 2'b00) begin bad++; $display("[TB] FAIL reset_fresh: got %b required 00", {a_fresh, b_fresh}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    int t0 = -1;
    int nStb = 0;
    int nFresh = 0;
    int stbAt[4] = '{-1, -1, -1, -1};
    int expAt[4] = '{0, 3, 6, 9};
    logic [36:0] expw;
    for (int i = 0; i < 4; i++) begin
      qa.push_back({(i == 3), 36'hA00000000 + 36'(i)});
      sbq.push_back({1'b0, 36'hA00000000 + 36'(i)});
    end
    for (int t = 0; t < 40; t++) begin
      tick();
      if (accA && t0 < 0) t0 = tickNo;
      if (a_fresh) nFresh++;
      if (o_stb) begin
        if (nStb < 4) stbAt[nStb] = tickNo - t0;
        nStb++;
        total++;
        if (sbq.size() == 0) begin bad++; $display("[TB] FAIL burst_extra: got %h required none", {o_src, o_word}); end
        else begin
          expw = sbq.pop_front();
          if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL burst_word: got %h required %h", {o_src, o_word}, expw); end
        end
      end
    end
    total++; if (nFresh != 1) begin bad++; $display("[TB] FAIL burst_fresh: got %0d required 1", nFresh); end
    total++; if (nStb != 4) begin bad++; $display("[TB] FAIL burst_count: got %0d required 4", nStb); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (stbAt[i] != expAt[i]) begin bad++; $display("[TB] FAIL burst_spacing%0d: got %0d required %0d", i, stbAt[i], expAt[i]); end
    end
    total++; if (o_word !== 36'hA00000003) begin bad++; $display("[TB] FAIL burst_hold: got %h required a00000003", o_word); end
    total++; if ({a_busy, b_busy} !== 2'b11) begin bad++; $display("[TB] FAIL burst_idle: got %b required 11", {a_busy, b_busy}); end
  endtask

  task automatic test_round_robin();
    int nFreshA = 0;
    int nFreshB = 0;
    int firstFresh = -1;
    int tieFirst = -1;
    logic [36:0] expw;
    pulseReset();
    qa.push_back({1'b0, 36'h0A1000001}); qa.push_back({1'b1, 36'h0A1000002});
    qb.push_back({1'b0, 36'h0B1000001}); qb.push_back({1'b1, 36'h0B1000002});
    sbq.push_back({1'b0, 36'h0A1000001}); sbq.push_back({1'b0, 36'h0A1000002});
    sbq.push_back({1'b1, 36'h0B1000001}); sbq.push_back({1'b1, 36'h0B1000002});
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 1) begin
        qa.push_back({1'b1, 36'h0A1000003});
        sbq.push_back({1'b0, 36'h0A1000003});
      end else if (phase == 2) begin
        qa.push_back({1'b1, 36'h0A1000004});
        qb.push_back({1'b1, 36'h0B1000003});
`ifdef WBUARB_PRIORITY_EN
        sbq.push_back({1'b0, 36'h0A1000004}); sbq.push_back({1'b1, 36'h0B1000003});
`else
        sbq.push_back({1'b1, 36'h0B1000003}); sbq.push_back({1'b0, 36'h0A1000004});
`endif
      end
      for (int t = 0; t < 40; t++) begin
        tick();
        if (a_fresh) nFreshA++;
        if (b_fresh) nFreshB++;
        if ((a_fresh || b_fresh) && phase == 0 && firstFresh < 0) firstFresh = int'(b_fresh);
        if ((a_fresh || b_fresh) && phase == 2 && tieFirst < 0) tieFirst = int'(b_fresh);
        if (o_stb) begin
          total++;
          if (sbq.size() == 0) begin bad++; $display("[TB] FAIL rr_extra: got %h required none", {o_src, o_word}); end
          else begin
            expw = sbq.pop_front();
            if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL rr_word: got %h required %h", {o_src, o_word}, expw); end
          end
        end
      end
    end
    total++; if (firstFresh != 0) begin bad++; $display("[TB] FAIL rr_first_grant: got %0d required 0", firstFresh); end
`ifdef WBUARB_PRIORITY_EN
    total++; if (tieFirst != 0) begin bad++; $display("[TB] FAIL rr_tie_grant: got %0d required 0", tieFirst); end
`else
    total++; if (tieFirst != 1) begin bad++; $display("[TB] FAIL rr_tie_grant: got %0d required 1", tieFirst); end
`endif
    total++; if (nFreshA != 3 || nFreshB != 2) begin bad++; $display("[TB] FAIL rr_fresh_count: got a=%0d b=%0d required a=3 b=2", nFreshA, nFreshB); end
    total++; if (sbq.size() != 0) begin bad++; $display("[TB] FAIL rr_leftover: got %0d required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_timeout();
    int ta = -1;
    int freshAt = -1;
    int accBAt = -1;
    logic [36:0] expw;
    qa.push_back({1'b0, 36'h0A5555555});
    sbq.push_back({1'b0, 36'h0A5555555});
    sbq.push_back({1'b1, 36'h0B4444444});
    for (int t = 0; t < 20 && ta < 0; t++) begin
      tick();
      if (accA) ta = tickNo;
      if (o_stb) begin
        total++;
        expw = sbq.pop_front();
        if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL to_word_a: got %h required %h", {o_src, o_word}, expw); end
      end
    end
    total++; if (ta < 0) begin bad++; $display("[TB] FAIL to_a_accept: got none required accept"); end
    qb.push_back({1'b1, 36'h0B4444444});
    for (int t = 0; t < 30; t++) begin
      tick();
      if (accBAt < 0) begin
        total++;
        if (!accB && preBBusy !== 1'b1) begin bad++; $display("[TB] FAIL to_b_busy: got %b required 1 at +%0d", preBBusy, tickNo - ta); end
      end
      if (accB && accBAt < 0) accBAt = tickNo;
      if (b_fresh && freshAt < 0) freshAt = tickNo;
      if (o_stb) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("[TB] FAIL to_extra: got %h required none", {o_src, o_word}); end
        else begin
          expw = sbq.pop_front();
          if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL to_word_b: got %h required %h", {o_src, o_word}, expw); end
        end
      end
    end
    total++; if (freshAt - ta != 18) begin bad++; $display("[TB] FAIL to_grant_time: got %0d required 18", freshAt - ta); end
    total++; if (accBAt - ta != 19) begin bad++; $display("[TB] FAIL to_accept_time: got %0d required 19", accBAt - ta); end
    total++; if (sbq.size() != 0) begin bad++; $display("[TB] FAIL to_leftover: got %0d required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] expw;
    a1_stb = 1'b1; a1_word = 36'hC0000FFFF; a1_last = 1'b0;
    @(posedge clk); #1;
    total++; if (a1_fresh !== 1'b1) begin bad++; $display("[TB] FAIL b2b_fresh: got %b required 1", a1_fresh); end
    for (int k = 0; k < 6; k++) begin
      a1_word = 36'hC00000000 + 36'(k * 7 + 1);
      a1_last = (k == 5);
      sb1.push_back(a1_word);
      @(posedge clk); #1;
      total++;
      if (o1_stb !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stb%0d: got %b required 1", k, o1_stb); end
      expw = sb1.pop_front();
      total++;
      if (o1_word !== expw || o1_src !== 1'b0) begin bad++; $display("[TB] FAIL b2b_word%0d: got %h src %b required %h src 0", k, o1_word, o1_src, expw); end
    end
    a1_stb = 1'b0; a1_last = 1'b0;
    @(posedge clk); #1;
    total++; if (o1_stb !== 1'b0) begin bad++; $display("[TB] FAIL b2b_release: got %b required 0", o1_stb); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_gap();
    logic found = 1'b0;
    int nFresh = 0;
    logic [36:0] expw;
    qa.push_back({1'b0, 36'h0D0000001}); qa.push_back({1'b0, 36'h0D0000002}); qa.push_back({1'b0, 36'h0D0000003});
    sbq.push_back({1'b0, 36'h0D0000001});
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (o_stb) begin
        total++;
        expw = sbq.pop_front();
        if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL rst_word: got %h required %h", {o_src, o_word}, expw); end
      end
      if (accA) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL rst_accept: got none required accept"); end
    rst_n = 1'b0;
    qa.delete();
    drive();
    #1;
    total++; if (o_stb !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_stb: got %b required 0", o_stb); end
    total++; if ({a_busy, b_busy} !== 2'b11) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b required 11", {a_busy, b_busy}); end
    total++; if (o_word !== 36'h0) begin bad++; $display("[TB] FAIL rst_mid_word: got %h required 0", o_word); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa.push_back({1'b1, 36'h0D0000009});
    sbq.push_back({1'b0, 36'h0D0000009});
    for (int t = 0; t < 15; t++) begin
      tick();
      if (a_fresh) nFresh++;
      if (o_stb) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("[TB] FAIL rst_extra: got %h required none", {o_src, o_word}); end
        else begin
          expw = sbq.pop_front();
          if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL rst_new_word: got %h required %h", {o_src, o_word}, expw); end
        end
      end
    end
    total++; if (nFresh != 1) begin bad++; $display("[TB] FAIL rst_refresh: got %0d required 1", nFresh); end
    total++; if (sbq.size() != 0) begin bad++; $display("[TB] FAIL rst_leftover: got %0d required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_nonowner_toggle();
    logic [36:0] expw;
    for (int i = 0; i < 3; i++) begin
      qa.push_back({(i == 2), 36'h0E0000000 + 36'(i)});
      sbq.push_back({1'b0, 36'h0E0000000 + 36'(i)});
    end
    tick();
    total++; if (a_fresh !== 1'b1) begin bad++; $display("[TB] FAIL tog_grant: got %b required 1", a_fresh); end
    bToggle = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bToggle) begin
        total++;
        if (preBBusy !== 1'b1) begin bad++; $display("[TB] FAIL tog_b_busy: got %b required 1", preBBusy); end
      end
      if (o_stb) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("[TB] FAIL tog_extra: got %h required none", {o_src, o_word}); end
        else begin
          expw = sbq.pop_front();
          if ({o_src, o_word} !== expw) begin bad++; $display("[TB] FAIL tog_word: got %h required %h", {o_src, o_word}, expw); end
        end
        if (sbq.size() == 0) begin
          bToggle = 1'b0;
          b_stb = 1'b0;
        end
      end
    end
    total++; if (bToggle !== 1'b0) begin bad++; $display("[TB] FAIL tog_timeout: got %0d words left required 0", sbq.size()); bToggle = 1'b0; end
    total++; if ({a_busy, b_busy} !== 2'b11) begin bad++; $display("[TB] FAIL tog_idle: got %b required 11", {a_busy, b_busy}); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_timeout();
    test_back_to_back();
    test_reset_mid_gap();
    test_nonowner_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
